// File: rtl/digital_clock_if.sv
// Control and display bundle of the digital clock: edit/enable controls in,
// displayed register set and alarm/timer flags out.
interface digital_clock_if;
    logic [1:0] mode;
    logic [1:0] select;
    logic       increment;
    logic       alarm_enable;
    logic       timer_enable;
    logic [5:0] sec_out;
    logic [5:0] min_out;
    logic [4:0] hour_out;
    logic       alarm_out;
    logic       timer_out;

    modport master (
        output mode, select, increment, alarm_enable, timer_enable,
        input  sec_out, min_out, hour_out, alarm_out, timer_out
    );

    modport slave (
        input  mode, select, increment, alarm_enable, timer_enable,
        output sec_out, min_out, hour_out, alarm_out, timer_out
    );
endinterface

// File: rtl/digital_clock.sv
// 24-hour clock with one alarm and one countdown timer; a prescaler turns clk
// into a 1 Hz tick and mode picks which register set is displayed and edited.
module digital_clock #(
    parameter int CLK_PER_SEC = 50_000_000
) (
    input  logic           clk,
    input  logic           reset,
    digital_clock_if.slave bus
);
    localparam int CW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_PER_SEC - 1);

    typedef struct packed {
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
    } hms_t;

    typedef enum logic [1:0] {
        MODE_CLOCK = 2'd0,
        MODE_ALARM = 2'd1,
        MODE_TIMER = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_SEC  = 2'd1,
        SEL_MIN  = 2'd2,
        SEL_HOUR = 2'd3
    } sel_e;

    localparam hms_t ONE_SEC = '{hour: 5'd0, min: 6'd0, sec: 6'd1};

    // Edits step one field and wrap inside it; they never carry.
    function automatic hms_t bump(hms_t v, sel_e sel);
        hms_t r;
        r = v;
        case (sel)
            SEL_SEC:  r.sec  = (v.sec  == 6'd59) ? 6'd0 : v.sec  + 6'd1;
            SEL_MIN:  r.min  = (v.min  == 6'd59) ? 6'd0 : v.min  + 6'd1;
            SEL_HOUR: r.hour = (v.hour == 5'd23) ? 5'd0 : v.hour + 5'd1;
            default:  r = v;
        endcase
        return r;
    endfunction

    function automatic hms_t tick_up(hms_t v);
        hms_t r;
        r = v;
        if (v.sec != 6'd59) begin
            r.sec = v.sec + 6'd1;
        end else begin
            r.sec = 6'd0;
            if (v.min != 6'd59) begin
                r.min = v.min + 6'd1;
            end else begin
                r.min  = 6'd0;
                r.hour = (v.hour == 5'd23) ? 5'd0 : v.hour + 5'd1;
            end
        end
        return r;
    endfunction

    // Only called with a non-zero value, so the hour borrow cannot underflow.
    function automatic hms_t tick_down(hms_t v);
        hms_t r;
        r = v;
        if (v.sec != 6'd0) begin
            r.sec = v.sec - 6'd1;
        end else begin
            r.sec = 6'd59;
            if (v.min != 6'd0) begin
                r.min = v.min - 6'd1;
            end else begin
                r.min  = 6'd59;
                r.hour = v.hour - 5'd1;
            end
        end
        return r;
    endfunction

    mode_e         mode;
    sel_e          sel;
    logic [CW-1:0] cnt;
    logic          tick;
    logic          inc_q;
    logic          inc_pulse;
    logic          edit_time, edit_alarm, edit_timer;
    logic          expired;
    logic          alarm_q;
    hms_t          tm, al, tr, shown;

    assign mode      = mode_e'(bus.mode);
    assign sel       = sel_e'(bus.select);
    assign tick      = (cnt == CNT_MAX);
    assign inc_pulse = bus.increment & ~inc_q;

    always_comb begin
        edit_time  = 1'b0;
        edit_alarm = 1'b0;
        edit_timer = 1'b0;
        if (inc_pulse && sel != SEL_NONE) begin
            case (mode)
                MODE_ALARM: edit_alarm = 1'b1;
                MODE_TIMER: edit_timer = 1'b1;
                default:    edit_time  = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            inc_q   <= 1'b0;
            tm      <= '0;
            al      <= '0;
            tr      <= '0;
            expired <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            cnt     <= tick ? '0 : cnt + CW'(1);
            inc_q   <= bus.increment;
            alarm_q <= bus.alarm_enable && (tm == al);

            // An edit on the same cycle as a tick swallows that tick.
            if (edit_time)
                tm <= bump(tm, sel);
            else if (tick)
                tm <= tick_up(tm);

            if (edit_alarm)
                al <= bump(al, sel);

            if (edit_timer) begin
                tr      <= bump(tr, sel);
                expired <= 1'b0;
            end else if (!bus.timer_enable) begin
                expired <= 1'b0;
            end else if (tick && tr != '0) begin
                tr <= tick_down(tr);
                if (tr == ONE_SEC)
                    expired <= 1'b1;
            end
        end
    end

    always_comb begin
        shown = tm;
        case (mode)
            MODE_ALARM: shown = al;
            MODE_TIMER: shown = tr;
            default:    shown = tm;
        endcase
    end

    assign bus.sec_out   = shown.sec;
    assign bus.min_out   = shown.min;
    assign bus.hour_out  = shown.hour;
    assign bus.alarm_out = alarm_q;
    assign bus.timer_out = expired;
endmodule

// File: tb/tb_digital_clock.sv
// Scoreboard bench for digital_clock: a seconds-of-day reference model predicts
// every cycle's outputs, a negedge monitor pops and compares them.
module tb_digital_clock;
    localparam int CPS = 2;
    localparam int DAY = 86400;

    typedef struct {
        int sec;
        int min;
        int hour;
        bit al;
        bit tm;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    digital_clock_if bus();

    digital_clock #(.CLK_PER_SEC(CPS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    exp_t sb[$];

    // Reference state: whole registers as seconds counts.
    int t_s, a_s, r_s, pres;
    bit inc_q, alarm_q, expired;
    int c_mode, c_sel;
    bit c_inc, c_aen, c_ten;

    function automatic int bump(int v, int sel);
        int h, m, s;
        h = v / 3600;
        m = (v / 60) % 60;
        s = v % 60;
        if (sel == 1) s = (s + 1) % 60;
        if (sel == 2) m = (m + 1) % 60;
        if (sel == 3) h = (h + 1) % 24;
        return h * 3600 + m * 60 + s;
    endfunction

    task automatic model_reset();
        t_s = 0; a_s = 0; r_s = 0; pres = 0;
        inc_q = 0; alarm_q = 0; expired = 0;
    endtask

    task automatic model_clock();
        bit tick, edit;
        int tgt;
        tick = (pres == CPS - 1);
        edit = c_inc && !inc_q && (c_sel != 0);
        tgt  = (c_mode == 1) ? 1 : (c_mode == 2) ? 2 : 0;
        alarm_q = c_aen && (t_s == a_s);
        pres  = tick ? 0 : pres + 1;
        inc_q = c_inc;
        if (edit && tgt == 0) t_s = bump(t_s, c_sel);
        else if (tick)        t_s = (t_s + 1) % DAY;
        if (edit && tgt == 1) a_s = bump(a_s, c_sel);
        if (edit && tgt == 2) begin
            r_s = bump(r_s, c_sel);
            expired = 0;
        end else if (!c_ten) begin
            expired = 0;
        end else if (tick && r_s != 0) begin
            r_s = r_s - 1;
            if (r_s == 0) expired = 1;
        end
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        int v;
        v = (c_mode == 1) ? a_s : (c_mode == 2) ? r_s : t_s;
        e.sec  = v % 60;
        e.min  = (v / 60) % 60;
        e.hour = v / 3600;
        e.al   = alarm_q;
        e.tm   = expired;
        return e;
    endfunction

    task automatic drive(int m, int s, bit i, bit ae, bit te);
        c_mode = m; c_sel = s; c_inc = i; c_aen = ae; c_ten = te;
        bus.mode = 2'(m);
        bus.select = 2'(s);
        bus.increment = i;
        bus.alarm_enable = ae;
        bus.timer_enable = te;
    endtask

    // One clock: account for the edge just taken, then apply new inputs.
    task automatic step(int m, int s, bit i, bit ae, bit te);
        @(posedge clk);
        #1;
        model_clock();
        drive(m, s, i, ae, te);
        sb.push_back(expect_now());
    endtask

    task automatic pulse(int m, int s, bit ae, bit te);
        step(m, s, 1'b1, ae, te);
        step(m, s, 1'b0, ae, te);
    endtask

    task automatic check_direct(string name, int h, int m, int s, bit al, bit tm);
        vectors++;
        if (bus.hour_out !== 5'(h) || bus.min_out !== 6'(m) || bus.sec_out !== 6'(s) ||
            bus.alarm_out !== al || bus.timer_out !== tm) begin
            miscompares++;
            $display("FAIL %s: got %0d:%0d:%0d al=%0b tm=%0b, want %0d:%0d:%0d al=%0b tm=%0b",
                     name, bus.hour_out, bus.min_out, bus.sec_out, bus.alarm_out, bus.timer_out,
                     h, m, s, al, tm);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if (bus.sec_out !== 6'(e.sec) || bus.min_out !== 6'(e.min) ||
                bus.hour_out !== 5'(e.hour) || bus.alarm_out !== e.al || bus.timer_out !== e.tm) begin
                miscompares++;
                $display("FAIL outputs t=%0t: got %0d:%0d:%0d al=%0b tm=%0b, want %0d:%0d:%0d al=%0b tm=%0b",
                         $time, bus.hour_out, bus.min_out, bus.sec_out, bus.alarm_out, bus.timer_out,
                         e.hour, e.min, e.sec, e.al, e.tm);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish before 1000000");
        $fatal(1);
    end

    initial begin
        int tgt;
        bit ten_r;
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #2;
        check_direct("reset_state", 0, 0, 0, 1'b0, 1'b0);
        #10 reset = 1'b1;

        // Free run: 62 seconds in CLOCK mode crosses the 59->0 seconds carry.
        repeat (CPS * 62) step(0, 0, 1'b0, 1'b0, 1'b0);
        #3;
        check_direct("run_62s", 0, 1, 2, 1'b0, 1'b0);

        // Reach 23:59:xx by edits, then let ticks roll through midnight.
        for (int n = 0; n < 400; n++) begin
            if (t_s / 3600 != 23)           pulse(0, 3, 1'b0, 1'b0);
            else if ((t_s / 60) % 60 != 59) pulse(0, 2, 1'b0, 1'b0);
            else break;
        end
        for (int n = 0; n < CPS * 62 && t_s != 0; n++) step(0, 0, 1'b0, 1'b0, 1'b0);
        #3;
        check_direct("midnight_wrap", 0, 0, 0, 1'b0, 1'b0);

        // Edit-wrap checks in CLOCK; holding increment high gives a single step.
        for (int n = 0; n < 30 && (t_s / 60) % 60 != 59; n++) pulse(0, 2, 1'b0, 1'b0);
        pulse(0, 2, 1'b0, 1'b0);
        for (int n = 0; n < 30 && t_s / 3600 != 23; n++) pulse(0, 3, 1'b0, 1'b0);
        pulse(0, 3, 1'b0, 1'b0);
        pulse(0, 1, 1'b0, 1'b0);
        repeat (10) step(0, 1, 1'b1, 1'b0, 1'b0);
        step(0, 1, 1'b0, 1'b0, 1'b0);

        // Alarm: program it a little ahead of the time, then watch it fire.
        tgt = (t_s + 150) % DAY;
        for (int n = 0; n < 300 && a_s != tgt; n++) begin
            if (a_s / 3600 != tgt / 3600)                 pulse(1, 3, 1'b0, 1'b0);
            else if ((a_s / 60) % 60 != (tgt / 60) % 60) pulse(1, 2, 1'b0, 1'b0);
            else                                          pulse(1, 1, 1'b0, 1'b0);
        end
        for (int n = 0; n < 800 && t_s != (tgt + 2) % DAY; n++) step(0, 0, 1'b0, 1'b1, 1'b0);
        repeat (3) step(0, 0, 1'b0, 1'b0, 1'b0);

        // Timer: 3 s countdown, expiry holds at zero, disable clears it.
        for (int n = 0; n < 70 && r_s != 0; n++) pulse(2, 1, 1'b0, 1'b0);
        repeat (3) pulse(2, 1, 1'b0, 1'b0);
        repeat (CPS * 5) step(2, 0, 1'b0, 1'b0, 1'b1);
        #3;
        check_direct("timer_expired", 0, 0, 0, 1'b0, 1'b1);
        repeat (3) step(2, 0, 1'b0, 1'b0, 1'b0);

        // Random traffic across all modes and fields.
        ten_r = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) ten_r = ~ten_r;
            step($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), ten_r);
        end

        // Asynchronous reset with the timer running and the alarm matching.
        for (int n = 0; n < 70 && r_s != 0; n++) pulse(2, 1, 1'b0, 1'b0);
        repeat (5) pulse(2, 1, 1'b0, 1'b0);
        a_s = a_s; // alarm register is edited below to the current time
        for (int n = 0; n < 300 && a_s != t_s; n++) begin
            if (a_s / 3600 != t_s / 3600)                 pulse(1, 3, 1'b0, 1'b0);
            else if ((a_s / 60) % 60 != (t_s / 60) % 60) pulse(1, 2, 1'b0, 1'b0);
            else                                          pulse(1, 1, 1'b0, 1'b0);
        end
        step(2, 0, 1'b0, 1'b1, 1'b1);
        step(2, 0, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        model_clock();
        #1 reset = 1'b0;
        #1;
        sb.delete();
        model_reset();
        check_direct("async_reset_timer", 0, 0, 0, 1'b0, 1'b0);
        drive(0, 0, 1'b0, 1'b1, 1'b1);
        #1 check_direct("async_reset_clock", 0, 0, 0, 1'b0, 1'b0);
        drive(1, 0, 1'b0, 1'b1, 1'b1);
        #1 check_direct("async_reset_alarm", 0, 0, 0, 1'b0, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (CPS * 4) step(0, 0, 1'b0, 1'b0, 1'b0);

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
